// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: op encodings, FSM states,
// bus size codes and small decode helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic half;
        logic word;
        half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word = (op == OP_LW) || (op == OP_SW);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] s;
        s = SIZE_WORD;
        if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB)) s = SIZE_BYTE;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) s = SIZE_HALF;
        return s;
    endfunction

    // Store data is replicated across every lane so the bus can pick by byte enable.
    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        if (op == OP_SB) w = {4{d[7:0]}};
        else if (op == OP_SH) w = {2{d[15:0]}};
        return w;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a word-aligned load and sign/zero extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] res
);

    logic [7:0]  bytes [4];
    logic [7:0]  b;
    logic [15:0] h;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign bytes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign b = bytes[lane];
    assign h = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        res = rdata;
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            default: res = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one bus transaction per load/store,
// flags misaligned accesses, and emits a single-cycle writeback pulse.
module mem_access
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [3:0]  mem_op,
    input  logic        wreg,
    input  logic [4:0]  rn,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        wb_valid,
    output logic        wb_wreg,
    output logic [4:0]  wb_rn,
    output logic [31:0] wb_res,
    output logic        wb_adel,
    output logic        wb_ades
);

    state_e      state_reg, state_next;
    logic [3:0]  op_reg;
    logic        wreg_reg;
    logic [4:0]  rn_reg;
    logic        accept;
    logic        acc_mem;
    logic        acc_bad;
    logic        done;
    logic [31:0] load_res;

    assign in_ready = (state_reg == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign acc_mem  = is_load(mem_op) || is_store(mem_op);
    assign acc_bad  = misaligned(mem_op, ea[1:0]);
    assign done     = ((state_reg == S_REQ) && data_addr_ok && data_data_ok) ||
                      ((state_reg == S_WAIT) && data_data_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept && acc_mem && !acc_bad) state_next = S_REQ;
            S_REQ:  if (data_addr_ok) state_next = data_data_ok ? S_IDLE : S_WAIT;
            S_WAIT: if (data_data_ok) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // data_addr doubles as the latched ea, so its low bits select the load lane.
    load_align u_align (
        .op    (op_reg),
        .lane  (data_addr[1:0]),
        .rdata (data_rdata),
        .res   (load_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg     <= '0;
            wreg_reg   <= 1'b0;
            rn_reg     <= '0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_wreg    <= 1'b0;
            wb_rn      <= '0;
            wb_res     <= '0;
            wb_adel    <= 1'b0;
            wb_ades    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_adel  <= 1'b0;
            wb_ades  <= 1'b0;
            if (accept) begin
                op_reg     <= mem_op;
                wreg_reg   <= wreg;
                rn_reg     <= rn;
                data_addr  <= ea;
                data_wdata <= store_data(mem_op, eb);
                if (!acc_mem) begin
                    wb_valid <= 1'b1;
                    wb_wreg  <= wreg;
                    wb_rn    <= rn;
                    wb_res   <= ea;
                end else if (acc_bad) begin
                    wb_valid <= 1'b1;
                    wb_wreg  <= 1'b0;
                    wb_rn    <= rn;
                    wb_res   <= ea;
                    wb_adel  <= is_load(mem_op);
                    wb_ades  <= is_store(mem_op);
                end else begin
                    data_req  <= 1'b1;
                    data_wr   <= is_store(mem_op);
                    data_size <= op_size(mem_op);
                end
            end
            if ((state_reg == S_REQ) && data_addr_ok) data_req <= 1'b0;
            if (done) begin
                wb_valid <= 1'b1;
                wb_wreg  <= is_load(op_reg) && wreg_reg;
                wb_rn    <= rn_reg;
                wb_res   <= is_load(op_reg) ? load_res : data_addr;
            end
        end
    end

endmodule
